// File: rtl/cnn_fmap_streamer.sv
// cnn_fmap_streamer: turns line-buffer fetch commands into word reads
// over a configured 2-D feature-map region, returning data in order.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg_start         start pulse (IDLE only), latches cfg_* below
//   cfg_base_addr     byte address of word (0,0)
//   cfg_row_stride    byte distance between row starts
//   cfg_width         last x index (row words - 1)
//   cfg_depth         last y index (rows - 1)
//   busy              not IDLE
//   done              one-cycle pulse once the region is fully answered
//   rsp_err           sticky: memory response with no read in flight
//   lacc_data_valid   fetch command in
//   lacc_data_ready   command accepted when valid & ready
//   lacc_drsp_valid   response word valid (no backpressure)
//   lacc_drsp_rdata   response word
//   mem_req_valid     memory read request
//   mem_req_ready     memory accepts request
//   mem_req_addr      request byte address
//   mem_rsp_valid     memory read data valid, in request order
//   mem_rsp_rdata     memory read data

module cnn_fmap_streamer #(
    parameter int ADDR_W  = 32,
    parameter int BUF_W   = 32,
    parameter int BUF_D   = 8,
    parameter int MAX_OUT = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cfg_start,
    input  logic [ADDR_W-1:0]                     cfg_base_addr,
    input  logic [ADDR_W-1:0]                     cfg_row_stride,
    input  logic [((BUF_W > 1) ? $clog2(BUF_W) : 1)-1:0] cfg_width,
    input  logic [((BUF_D > 1) ? $clog2(BUF_D) : 1)-1:0] cfg_depth,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  rsp_err,
    input  logic                                  lacc_data_valid,
    output logic                                  lacc_data_ready,
    output logic                                  lacc_drsp_valid,
    output logic [31:0]                           lacc_drsp_rdata,
    output logic                                  mem_req_valid,
    input  logic                                  mem_req_ready,
    output logic [ADDR_W-1:0]                     mem_req_addr,
    input  logic                                  mem_rsp_valid,
    input  logic [31:0]                           mem_rsp_rdata
);

    localparam int XW = (BUF_W > 1) ? $clog2(BUF_W) : 1;
    localparam int YW = (BUF_D > 1) ? $clog2(BUF_D) : 1;
    localparam int OW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [XW-1:0]     width_q;
    logic [YW-1:0]     depth_q;
    logic [ADDR_W-1:0] stride_q;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] row_addr;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     in_flight;

    logic cmd_hs;
    logic req_fire;
    logic rsp_ok;
    logic rsp_bad;
    logic start_acc;
    logic last_word;
    logic row_end;

    assign cmd_hs    = lacc_data_valid & lacc_data_ready;
    assign req_fire  = mem_req_valid & mem_req_ready;
    assign rsp_ok    = mem_rsp_valid & (in_flight != '0);
    assign rsp_bad   = mem_rsp_valid & (in_flight == '0);
    assign start_acc = (state == S_IDLE) & cfg_start;
    assign row_end   = (x == width_q);
    assign last_word = row_end & (y == depth_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (cmd_hs && last_word) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (outstanding == '0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state. A command is only taken when the
    // request register is free or draining this cycle, so requests
    // can still stream at one per cycle.
    always_comb begin
        busy            = (state != S_IDLE);
        lacc_data_ready = (state == S_RUN)
                        && (outstanding < OW'(MAX_OUT))
                        && (!mem_req_valid || mem_req_ready);
    end

    // Done pulses in the first IDLE cycle after DRAIN empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state == S_DRAIN) && (outstanding == '0);
        end
    end

    // Configuration latch and address walk
    always_ff @(posedge clk) begin
        if (rst) begin
            width_q  <= '0;
            depth_q  <= '0;
            stride_q <= '0;
            x        <= '0;
            y        <= '0;
            row_addr <= '0;
        end else if (start_acc) begin
            width_q  <= cfg_width;
            depth_q  <= cfg_depth;
            stride_q <= cfg_row_stride;
            x        <= '0;
            y        <= '0;
            row_addr <= cfg_base_addr;
        end else if (cmd_hs) begin
            if (row_end) begin
                x        <= '0;
                y        <= y + 1'b1;
                row_addr <= row_addr + stride_q;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // Memory request register: loaded on a command, held until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
        end else if (cmd_hs) begin
            mem_req_valid <= 1'b1;
            mem_req_addr  <= row_addr + (ADDR_W'(x) << 2);
        end else if (req_fire) begin
            mem_req_valid <= 1'b0;
        end
    end

    // Commands accepted but not yet answered on lacc_drsp
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({cmd_hs, lacc_drsp_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Reads accepted by memory but not yet returned
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight <= '0;
        end else begin
            case ({req_fire, rsp_ok})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    // Response register; data holds when no new word arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            lacc_drsp_valid <= 1'b0;
            lacc_drsp_rdata <= '0;
        end else begin
            lacc_drsp_valid <= rsp_ok;
            if (rsp_ok) begin
                lacc_drsp_rdata <= mem_rsp_rdata;
            end
        end
    end

    // Unexpected responses are dropped and flagged; a new error in
    // the same cycle as a start wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else if (rsp_bad) begin
            rsp_err <= 1'b1;
        end else if (start_acc) begin
            rsp_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cnn_fmap_streamer.sv
// tb_cnn_fmap_streamer: directed bench for cnn_fmap_streamer.
// Memory model answers each accepted request one cycle later.

module tb_cnn_fmap_streamer;

    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [31:0] cfg_base_addr;
    logic [31:0] cfg_row_stride;
    logic [4:0]  cfg_width;
    logic [2:0]  cfg_depth;
    logic        busy;
    logic        done;
    logic        rsp_err;
    logic        lacc_data_valid;
    logic        lacc_data_ready;
    logic        lacc_drsp_valid;
    logic [31:0] lacc_drsp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    int checks = 0;
    int errors = 0;

    logic        auto_rsp;
    logic        a_v = 1'b0;
    logic [31:0] a_d = '0;
    logic        m_v;
    logic [31:0] m_d;

    int          hs_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] req_q[$];
    logic [31:0] rsp_q[$];

    always #5 clk = ~clk;

    cnn_fmap_streamer dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_start       (cfg_start),
        .cfg_base_addr   (cfg_base_addr),
        .cfg_row_stride  (cfg_row_stride),
        .cfg_width       (cfg_width),
        .cfg_depth       (cfg_depth),
        .busy            (busy),
        .done            (done),
        .rsp_err         (rsp_err),
        .lacc_data_valid (lacc_data_valid),
        .lacc_data_ready (lacc_data_ready),
        .lacc_drsp_valid (lacc_drsp_valid),
        .lacc_drsp_rdata (lacc_drsp_rdata),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_rdata   (mem_rsp_rdata)
    );

    assign mem_rsp_valid = auto_rsp ? a_v : m_v;
    assign mem_rsp_rdata = auto_rsp ? a_d : m_d;

    always @(posedge clk) begin
        a_v <= mem_req_valid && mem_req_ready;
        a_d <= mem_req_addr ^ KEY;
    end

    always @(posedge clk) begin
        if (lacc_data_valid && lacc_data_ready) hs_cnt <= hs_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (mem_req_valid && mem_req_ready) req_q.push_back(mem_req_addr);
        if (lacc_drsp_valid) rsp_q.push_back(lacc_drsp_rdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_region(input logic [31:0] base,
                                input logic [31:0] stride,
                                input logic [4:0] w,
                                input logic [2:0] d);
        cfg_base_addr  = base;
        cfg_row_stride = stride;
        cfg_width      = w;
        cfg_depth      = d;
        cfg_start      = 1'b1;
        step();
        cfg_start      = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_hs(input int target, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (hs_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst = 1'b1;
        step();
        step();
        got = {busy, done, rsp_err, lacc_data_ready,
               lacc_drsp_valid, mem_req_valid, 2'b00};
        checks++;
        if (got !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got %h want 00", got);
        end
        checks++;
        if (lacc_drsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 0", lacc_drsp_rdata);
        end
        checks++;
        if (mem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h want 0", mem_req_addr);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int qb = req_q.size();
        int rb = rsp_q.size();
        int hb = hs_cnt;
        int db = done_cnt;
        bit ok;
        logic [31:0] exp;
        start_region(32'h1000, 32'h100, 5'd3, 3'd1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        lacc_data_valid = 1'b1;
        wait_done(200, ok);
        lacc_data_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done_timeout: got none want done");
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_fall: got %b want 0", busy);
        end
        checks++;
        if (hs_cnt - hb != 8) begin
            errors++;
            $display("FAIL basic_hs: got %0d want 8", hs_cnt - hb);
        end
        checks++;
        if (rsp_q.size() - rb != 8) begin
            errors++;
            $display("FAIL basic_drsp_cnt: got %0d want 8", rsp_q.size() - rb);
        end
        for (int i = 0; i < 8; i++) begin
            exp = 32'h1000 + 32'(i / 4) * 32'h100 + 32'(i % 4) * 4;
            checks++;
            if (req_q[qb + i] !== exp) begin
                errors++;
                $display("FAIL basic_addr%0d: got %h want %h", i, req_q[qb + i], exp);
            end
            checks++;
            if (rsp_q[rb + i] !== (exp ^ KEY)) begin
                errors++;
                $display("FAIL basic_data%0d: got %h want %h", i, rsp_q[rb + i], exp ^ KEY);
            end
        end
        step();
        checks++;
        if (done !== 1'b0 || done_cnt - db != 1) begin
            errors++;
            $display("FAIL basic_done_pulse: got done=%b n=%0d want 0/1", done, done_cnt - db);
        end
    endtask

    task automatic test_max_out();
        int hb = hs_cnt;
        auto_rsp = 1'b0;
        start_region(32'h5000, 32'h40, 5'd7, 3'd0);
        lacc_data_valid = 1'b1;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (hs_cnt - hb != 4) begin
            errors++;
            $display("FAIL maxout_hs: got %0d want 4", hs_cnt - hb);
        end
        checks++;
        if (lacc_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL maxout_ready_low: got %b want 0", lacc_data_ready);
        end
        m_d = 32'hDEAD_BEEF;
        m_v = 1'b1;
        step();
        m_v = 1'b0;
        checks++;
        if (lacc_drsp_valid !== 1'b1 || lacc_drsp_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL maxout_drsp: got %b/%h want 1/deadbeef",
                     lacc_drsp_valid, lacc_drsp_rdata);
        end
        checks++;
        if (lacc_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL maxout_ready_hold: got %b want 0", lacc_data_ready);
        end
        step();
        checks++;
        if (lacc_data_ready !== 1'b1) begin
            errors++;
            $display("FAIL maxout_ready_back: got %b want 1", lacc_data_ready);
        end
        step();
        checks++;
        if (hs_cnt - hb != 5 || lacc_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL maxout_refill: got hs=%0d rdy=%b want 5/0",
                     hs_cnt - hb, lacc_data_ready);
        end
        lacc_data_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        auto_rsp = 1'b1;
    endtask

    task automatic test_stall();
        int qb = req_q.size();
        int rb = rsp_q.size();
        int hb = hs_cnt;
        bit ok;
        logic [31:0] exp;
        start_region(32'h2000, 32'h100, 5'd3, 3'd0);
        lacc_data_valid = 1'b1;
        wait_hs(hb + 2, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_hs_timeout: got %0d want 2", hs_cnt - hb);
        end
        mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2004) begin
                errors++;
                $display("FAIL stall_req%0d: got %b/%h want 1/2004",
                         i, mem_req_valid, mem_req_addr);
            end
            checks++;
            if (lacc_data_ready !== 1'b0 || hs_cnt - hb != 2) begin
                errors++;
                $display("FAIL stall_ready%0d: got %b hs=%0d want 0/2",
                         i, lacc_data_ready, hs_cnt - hb);
            end
        end
        mem_req_ready = 1'b1;
        wait_done(100, ok);
        lacc_data_valid = 1'b0;
        checks++;
        if (!ok || hs_cnt - hb != 4 || req_q.size() - qb != 4) begin
            errors++;
            $display("FAIL stall_counts: got ok=%b hs=%0d req=%0d want 1/4/4",
                     ok, hs_cnt - hb, req_q.size() - qb);
        end
        for (int i = 0; i < 4; i++) begin
            exp = 32'h2000 + 32'(i) * 4;
            checks++;
            if (req_q[qb + i] !== exp || rsp_q[rb + i] !== (exp ^ KEY)) begin
                errors++;
                $display("FAIL stall_word%0d: got %h/%h want %h/%h", i,
                         req_q[qb + i], rsp_q[rb + i], exp, exp ^ KEY);
            end
        end
    endtask

    task automatic test_single();
        int qb = req_q.size();
        int rb = rsp_q.size();
        int hb = hs_cnt;
        bit ok;
        start_region(32'h3000, 32'h100, 5'd0, 3'd0);
        lacc_data_valid = 1'b1;
        wait_hs(hb + 1, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_hs_timeout: got %0d want 1", hs_cnt - hb);
        end
        checks++;
        if (busy !== 1'b1 || lacc_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got busy=%b rdy=%b want 1/0",
                     busy, lacc_data_ready);
        end
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3000) begin
            errors++;
            $display("FAIL single_req: got %b/%h want 1/3000",
                     mem_req_valid, mem_req_addr);
        end
        wait_done(50, ok);
        lacc_data_valid = 1'b0;
        checks++;
        if (!ok || hs_cnt - hb != 1 || req_q.size() - qb != 1) begin
            errors++;
            $display("FAIL single_counts: got ok=%b hs=%0d req=%0d want 1/1/1",
                     ok, hs_cnt - hb, req_q.size() - qb);
        end
        checks++;
        if (rsp_q.size() - rb != 1 || rsp_q[rb] !== (32'h3000 ^ KEY)) begin
            errors++;
            $display("FAIL single_data: got n=%0d %h want 1/%h",
                     rsp_q.size() - rb, rsp_q[rb], 32'h3000 ^ KEY);
        end
    endtask

    task automatic test_rsp_err();
        bit ok;
        auto_rsp = 1'b0;
        m_d = 32'h1234_5678;
        m_v = 1'b1;
        step();
        m_v = 1'b0;
        checks++;
        if (rsp_err !== 1'b1 || lacc_drsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_set: got err=%b dv=%b want 1/0",
                     rsp_err, lacc_drsp_valid);
        end
        step();
        checks++;
        if (rsp_err !== 1'b1 || lacc_drsp_rdata !== (32'h3000 ^ KEY)) begin
            errors++;
            $display("FAIL err_sticky: got err=%b rd=%h want 1/%h",
                     rsp_err, lacc_drsp_rdata, 32'h3000 ^ KEY);
        end
        auto_rsp = 1'b1;
        start_region(32'h3100, 32'h100, 5'd0, 3'd0);
        checks++;
        if (rsp_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: got err=%b busy=%b want 0/1", rsp_err, busy);
        end
        lacc_data_valid = 1'b1;
        wait_done(50, ok);
        lacc_data_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL err_done_timeout: got none want done");
        end
    endtask

    task automatic test_rst_mid();
        int hb = hs_cnt;
        int qb;
        bit ok;
        logic [7:0] got;
        start_region(32'h4000, 32'h100, 5'd7, 3'd0);
        lacc_data_valid = 1'b1;
        wait_hs(hb + 3, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid_hs_timeout: got %0d want 3", hs_cnt - hb);
        end
        lacc_data_valid = 1'b0;
        rst = 1'b1;
        step();
        got = {busy, done, rsp_err, lacc_data_ready,
               lacc_drsp_valid, mem_req_valid, 2'b00};
        checks++;
        if (got !== 8'h00 || lacc_drsp_rdata !== 32'h0 || mem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %h/%h/%h want 00/0/0",
                     got, lacc_drsp_rdata, mem_req_addr);
        end
        rst = 1'b0;
        step();
        checks++;
        if (rsp_err !== 1'b1 || lacc_drsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_late_rsp: got err=%b dv=%b want 1/0",
                     rsp_err, lacc_drsp_valid);
        end
        step();
        qb = req_q.size();
        start_region(32'h4000, 32'h100, 5'd1, 3'd0);
        checks++;
        if (rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_err_clear: got %b want 0", rsp_err);
        end
        lacc_data_valid = 1'b1;
        wait_done(50, ok);
        lacc_data_valid = 1'b0;
        checks++;
        if (!ok || req_q.size() - qb != 2) begin
            errors++;
            $display("FAIL rstmid_restart: got ok=%b req=%0d want 1/2",
                     ok, req_q.size() - qb);
        end
        checks++;
        if (req_q[qb] !== 32'h4000 || req_q[qb + 1] !== 32'h4004) begin
            errors++;
            $display("FAIL rstmid_addr: got %h %h want 4000 4004",
                     req_q[qb], req_q[qb + 1]);
        end
    endtask

    initial begin
        rst             = 1'b1;
        cfg_start       = 1'b0;
        cfg_base_addr   = '0;
        cfg_row_stride  = '0;
        cfg_width       = '0;
        cfg_depth       = '0;
        lacc_data_valid = 1'b0;
        mem_req_ready   = 1'b1;
        auto_rsp        = 1'b1;
        m_v             = 1'b0;
        m_d             = '0;
        test_reset();
        test_basic();
        test_max_out();
        test_stall();
        test_single();
        test_rsp_err();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
